// File: rtl/c2sif_bridge.sv
// c2sif_bridge: responder for the C-side 4-phase packet handshake,
// issuing single or burst beats on a valid/ready register bus.
module c2sif_bridge #(
  parameter int DATA_SIZE = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  output logic                   ack,
  input  logic [31:0]            id,
  input  logic [31:0]            fn,
  input  logic [31:0]            addr,
  input  logic [32*DATA_SIZE-1:0] data,
  output logic [31:0]            ret,
  output logic [32*DATA_SIZE-1:0] rdata,
  output logic                   busy,
  output logic                   bus_valid,
  output logic                   bus_write,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  output logic [31:0]            bus_id,
  input  logic                   bus_ready,
  input  logic [31:0]            bus_rdata,
  input  logic                   bus_err
);

  localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [31:0] RET_ILL = 32'hFFFF_FFFF;
  localparam logic [31:0] RET_ERR = 32'hFFFF_FFFE;
  localparam logic [31:0] RET_TMO = 32'hFFFF_FFFD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_BEAT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t state, state_d;

  logic          req_m, req_s;
  logic          ack_d, busy_d, valid_d;
  logic [31:0]   ret_d;
  logic          cap, adv, store;
  logic          tmo_clr, tmo_inc;
  logic          wr_q, one_q;
  logic [31:0]   addr_q;
  logic [31:0]   dq [DATA_SIZE];
  logic [31:0]   rq [DATA_SIZE];
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo;
  logic [4:0]    nbeats;
  logic          last;
  logic          f_nop, f_ill, f_beat;
  logic          f_wr, f_one;

  assign f_nop  = (fn == 32'd0);
  assign f_ill  = (fn > 32'd4);
  assign f_beat = ~f_nop & ~f_ill;
  assign f_wr   = (fn == 32'd1) | (fn == 32'd3);
  assign f_one  = (fn == 32'd1) | (fn == 32'd2);

  assign nbeats = one_q ? 5'd1 : 5'(DATA_SIZE);
  assign last   = ({{(5-IW){1'b0}}, idx} == nbeats - 5'd1);

  assign bus_write = wr_q;
  assign bus_addr  = addr_q + {{(30-IW){1'b0}}, idx, 2'b00};
  assign bus_wdata = dq[idx];

  for (genvar g = 0; g < DATA_SIZE; g++) begin : g_rd
    assign rdata[32*g +: 32] = rq[g];
  end

  // req comes from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= req;
      req_s <= req_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ack_d   = ack;
    busy_d  = busy;
    valid_d = bus_valid;
    ret_d   = ret;
    cap     = 1'b0;
    adv     = 1'b0;
    store   = 1'b0;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_s && !ack) begin
          state_d = S_CAPTURE;
          busy_d  = 1'b1;
        end
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        tmo_clr = 1'b1;
        unique case (1'b1)
          f_nop: begin
            ret_d   = 32'd0;
            ack_d   = 1'b1;
            state_d = S_RESP;
          end
          f_ill: begin
            ret_d   = RET_ILL;
            ack_d   = 1'b1;
            state_d = S_RESP;
          end
          f_beat: begin
            valid_d = 1'b1;
            state_d = S_BEAT;
          end
        endcase
      end
      S_BEAT: begin
        // a ready in the timeout cycle still completes the beat
        if (bus_ready) begin
          tmo_clr = 1'b1;
          if (bus_err) begin
            ret_d   = RET_ERR;
            valid_d = 1'b0;
            ack_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            store = ~wr_q;
            if (last) begin
              ret_d   = 32'(nbeats);
              valid_d = 1'b0;
              ack_d   = 1'b1;
              state_d = S_RESP;
            end else begin
              adv = 1'b1;
            end
          end
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          ret_d   = RET_TMO;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      busy      <= 1'b0;
      bus_valid <= 1'b0;
      ret       <= '0;
    end else begin
      ack       <= ack_d;
      busy      <= busy_d;
      bus_valid <= valid_d;
      ret       <= ret_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_id <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      one_q  <= 1'b0;
      idx    <= '0;
      tmo    <= '0;
      for (int i = 0; i < DATA_SIZE; i++) begin
        dq[i] <= '0;
        rq[i] <= '0;
      end
    end else begin
      if (cap) begin
        bus_id <= id;
        addr_q <= addr;
        wr_q   <= f_wr;
        one_q  <= f_one;
        idx    <= '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
          dq[i] <= data[32*i +: 32];
          rq[i] <= '0;
        end
      end
      if (store) rq[idx] <= bus_rdata;
      if (adv)   idx <= idx + IW'(1);
      if (tmo_clr)      tmo <= '0;
      else if (tmo_inc) tmo <= tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_c2sif_bridge.sv
// tb_c2sif_bridge: directed packets with a queue scoreboard checked
// by an independent bus/ack monitor.
module tb_c2sif_bridge;

  localparam int DS = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req;
  logic            ack;
  logic [31:0]     id, fn, addr;
  logic [32*DS-1:0] data;
  logic [31:0]     ret;
  logic [32*DS-1:0] rdata;
  logic            busy;
  logic            bus_valid, bus_write;
  logic [31:0]     bus_addr, bus_wdata, bus_id;
  logic            bus_ready;
  logic [31:0]     bus_rdata;
  logic            bus_err;

  always #5 clk = ~clk;

  c2sif_bridge #(.DATA_SIZE(DS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .id(id), .fn(fn), .addr(addr), .data(data),
    .ret(ret), .rdata(rdata), .busy(busy),
    .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_id(bus_id),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] id;
  } beat_t;

  typedef struct {
    logic [31:0]  ret;
    logic [255:0] rd;
    int           nb;
    int           vc;
    int           lat;
    int           drop;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_req = 0;
  int hs_total = 0;
  int acks = 0;
  int rmode = 0;
  int err_beat = -1;

  function automatic void chk(string nm, logic [255:0] act,
                              logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [255:0] mk_data(logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < DS; i++) r[32*i +: 32] = b + 32'(i);
    return r;
  endfunction

  function automatic logic [255:0] mk_rd(int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[32*i +: 32] = 32'h5500_0000 + 32'(i);
    return r;
  endfunction

  task automatic exp_beats(logic [31:0] a, logic w, logic [255:0] d,
                           logic [31:0] i_id, int first, int n);
    for (int k = first; k < first + n; k++) begin
      beat_t b;
      b.addr  = a + 32'(4 * k);
      b.wr    = w;
      b.wdata = d[32*k +: 32];
      b.id    = i_id;
      beat_q.push_back(b);
    end
  endtask

  task automatic exp_resp(logic [31:0] r, logic [255:0] rd, int nb,
                          int vc, int lat, int drop);
    resp_t e;
    e.ret  = r;
    e.rd   = rd;
    e.nb   = nb;
    e.vc   = vc;
    e.lat  = lat;
    e.drop = drop;
    resp_q.push_back(e);
  endtask

  task automatic wait_ack(logic v, string nm);
    int k;
    k = 0;
    while (ack !== v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (ack !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: ack still %0b, required %0b", nm, ack, v);
    end
  endtask

  task automatic send(logic [31:0] i_id, logic [31:0] f,
                      logic [31:0] a, logic [255:0] d);
    id   = i_id;
    fn   = f;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    req   = 1'b1;
    t_req = cyc;
    wait_ack(1'b1, "ack_rise");
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_ack(1'b0, "ack_fall");
    repeat (2) @(posedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bus target: per-beat stall count chosen by rmode
  initial begin
    int rbeat;
    int waited;
    int st;
    rbeat = 0;
    waited = 0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    bus_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) begin
        rbeat = 0;
        waited = 0;
      end
      bus_ready = 1'b0;
      bus_err = 1'b0;
      if (bus_valid) begin
        st = (rmode == 2) ? 1000000 : (rmode == 1) ? rbeat % 4 : 0;
        if (waited < st) begin
          waited++;
        end else begin
          bus_ready = 1'b1;
          bus_rdata = 32'h5500_0000 + 32'(rbeat);
          bus_err = (rbeat == err_beat);
          waited = 0;
          rbeat++;
        end
      end
    end
  end

  initial begin
    beat_t b;
    resp_t e;
    logic  pack;
    logic  pbusy;
    int    pk_hs;
    int    vcyc;
    pack = 1'b0;
    pbusy = 1'b0;
    pk_hs = 0;
    vcyc = 0;
    forever begin
      @(negedge clk);
      if (busy && !pbusy) begin
        pk_hs = 0;
        vcyc = 0;
      end
      if (bus_valid) vcyc++;
      if (bus_valid && bus_ready) begin
        hs_total++;
        pk_hs++;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", bus_addr, 256'h1_0000_0000);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", bus_addr, b.addr);
          chk("beat_write", bus_write, b.wr);
          chk("beat_id", bus_id, b.id);
          if (b.wr) chk("beat_wdata", bus_wdata, b.wdata);
        end
      end else if (bus_valid && beat_q.size() > 0) begin
        b = beat_q[0];
        chk("stall_addr", bus_addr, b.addr);
        chk("stall_write", bus_write, b.wr);
        if (b.wr) chk("stall_wdata", bus_wdata, b.wdata);
      end
      if (ack && !pack) begin
        acks++;
        if (resp_q.size() == 0) begin
          chk("unexpected_ack", ret, 256'h1_0000_0000);
        end else begin
          e = resp_q.pop_front();
          for (int i = 0; i < e.drop; i++) begin
            if (beat_q.size() > 0) b = beat_q.pop_front();
          end
          chk("ret", ret, e.ret);
          chk("rdata", rdata, e.rd);
          chk("beat_count", 256'(pk_hs), 256'(e.nb));
          chk("valid_cycles", 256'(vcyc), 256'(e.vc));
          chk("beats_left", 256'(beat_q.size()), 256'(0));
          if (e.lat >= 0) chk("latency", 256'(cyc - t_req), 256'(e.lat));
        end
      end
      if (!ack && pack) chk("busy_at_ack_fall", busy, 1'b0);
      pack = ack;
      pbusy = busy;
    end
  end

  initial begin
    logic [255:0] d;
    int base;
    int k;
    rst_n = 1'b0;
    req = 1'b0;
    id = '0;
    fn = '0;
    addr = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_write", bus_write, 1'b0);
    chk("rst_ret", ret, 32'h0);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_id", bus_id, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    exp_resp(32'h0, '0, 0, 0, 4, 0);
    send(32'd7, 32'd0, 32'h100, '0);

    d = mk_data(32'hA0);
    exp_beats(32'h1000, 1'b1, d, 32'h11, 0, 8);
    exp_resp(32'd8, '0, 8, 8, 12, 0);
    send(32'h11, 32'd3, 32'h1000, d);

    rmode = 1;
    exp_beats(32'h3000, 1'b0, d, 32'h22, 0, 8);
    exp_resp(32'd8, mk_rd(8), 8, 20, 24, 0);
    send(32'h22, 32'd4, 32'h3000, d);
    rmode = 0;

    err_beat = 3;
    d = mk_data(32'hB0);
    exp_beats(32'h4000, 1'b1, d, 32'h33, 0, 4);
    exp_resp(32'hFFFF_FFFE, '0, 4, 4, -1, 0);
    send(32'h33, 32'd3, 32'h4000, d);
    err_beat = -1;

    rmode = 2;
    exp_beats(32'h5000, 1'b0, d, 32'h44, 0, 1);
    exp_resp(32'hFFFF_FFFD, '0, 0, TO, -1, 1);
    send(32'h44, 32'd2, 32'h5000, d);
    rmode = 0;

    exp_resp(32'hFFFF_FFFF, '0, 0, 0, 4, 0);
    send(32'h55, 32'd9, 32'h6000, d);

    exp_beats(32'hFFFF_FFFC, 1'b0, d, 32'h66, 0, 1);
    exp_resp(32'd1, mk_rd(1), 1, 1, 5, 0);
    send(32'h66, 32'd2, 32'hFFFF_FFFC, d);

    exp_beats(32'hFFFF_FFFC, 1'b0, d, 32'h77, 0, 8);
    exp_resp(32'd8, mk_rd(8), 8, 8, 12, 0);
    send(32'h77, 32'd4, 32'hFFFF_FFFC, d);

    d = mk_data(32'hC0);
    exp_beats(32'h2000, 1'b1, d, 32'h88, 0, 2);
    exp_beats(32'h2000, 1'b1, d, 32'h88, 0, 8);
    exp_resp(32'd8, '0, 8, 8, -1, 0);
    id = 32'h88;
    fn = 32'd3;
    addr = 32'h2000;
    data = d;
    base = hs_total;
    @(posedge clk);
    #1;
    req = 1'b1;
    k = 0;
    while (hs_total < base + 2 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reach_beat2", 256'(hs_total - base), 256'(2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_valid", bus_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_ack(1'b0, "rst_ack_fall");
    repeat (5) @(posedge clk);

    chk("ack_count", 256'(acks), 256'(9));
    chk("beats_pending", 256'(beat_q.size()), 256'(0));
    chk("resp_pending", 256'(resp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c2sif_bridge.md
Name: c2sif_bridge

Overview:
- Clocked responder for the C-to-SV packet handshake (req/ack, id, fn, addr, data[], ret).
- Accepts one packet per 4-phase handshake and decodes fn into single or burst transfers on a simple valid/ready register bus.
- Returns a status/word count in ret, and read data in rdata.
- Sits between the C-side packet driver and the SV register fabric; it is the only master on that bus.

Parameters:
- DATA_SIZE, 8, words in a packet data array; legal 1..16.
- TIMEOUT, 1024, max cycles a bus beat may wait for bus_ready before abort; >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  packet request from C side; asynchronous to clk
- ack  out  1  packet acknowledge
- id  in  32  packet tag, echoed on bus_id
- fn  in  32  function code
- addr  in  32  base byte address
- data  in  32*DATA_SIZE  write data; word i at bits [32i+31:32i]
- ret  out  32  signed status, valid while ack=1
- rdata  out  32*DATA_SIZE  read data, valid while ack=1
- busy  out  1  high from accept until ack falls
- bus_valid  out  1  beat request
- bus_write  out  1  1=write, 0=read
- bus_addr  out  32  beat byte address
- bus_wdata  out  32  write data
- bus_id  out  32  captured id
- bus_ready  in  1  beat accepted/completed
- bus_rdata  in  32  read data, valid with bus_ready
- bus_err  in  1  beat error, valid with bus_ready

Behaviour:
- Reset (async assert, sync release) drives ack, busy, bus_valid, bus_write = 0 and ret, rdata, bus_addr, bus_wdata, bus_id = 0; state IDLE; sync flops 0.
- req passes through a 2-flop synchronizer to req_s. id, fn, addr and data are stable whenever req=1 and are sampled without synchronization.
- fn encoding:
  - 0 NOP: no beats, ret=0.
  - 1 WR1: 1 write beat of data[0].
  - 2 RD1: 1 read beat into rdata[0].
  - 3 WRB: DATA_SIZE write beats.
  - 4 RDB: DATA_SIZE read beats.
  - Any other value: ILLEGAL, no beats, ret=-1.
- States: IDLE, CAPTURE, BEAT, RESP, RELEASE.
- IDLE: on req_s=1 with ack=0, go to CAPTURE and set busy=1. Start is level-sensitive, so a req held across reset starts a new packet.
- CAPTURE (1 cycle):
  - Latch id, fn, addr, data; clear rdata and the beat index.
  - NOP or ILLEGAL: go to RESP.
  - Otherwise: go to BEAT.
- BEAT:
  - bus_valid=1; bus_addr = addr + 4*index (mod 2^32 wrap, no error); bus_wdata = data[index].
  - bus_valid stays asserted and the fields stay stable until bus_ready.
  - On bus_ready with bus_err=0: store bus_rdata to rdata[index] for reads, then increment index. At the last index, drop bus_valid and go to RESP. Otherwise issue the next beat in the next cycle; bus_valid may stay high back to back.
  - On bus_ready with bus_err=1: ret=-2, abort remaining beats, go to RESP.
  - Per-beat timeout counter clears at each new beat. If it reaches TIMEOUT without bus_ready: ret=-3, drop bus_valid, go to RESP. A bus_ready arriving in the same cycle as the timeout wins.
  - Success ret = number of beats completed (1 or DATA_SIZE).
- RESP: ack=1, ret and rdata held. Go to RELEASE.
- RELEASE: hold ack=1 until req_s=0. Then ack=0 and busy=0 in the same edge, and return to IDLE.
- A new packet needs req_s=0 observed first. This prevents double acceptance.
- Minimum latency, req_s rise to ack rise: NOP = 2 cycles; WR1 with bus_ready in the same cycle as bus_valid = 3 cycles.
- req falling before ack (protocol violation) is ignored: the transaction completes and ack rises, then falls on the next req_s=0.
- rst_n asserted mid-burst: bus_valid drops immediately and the partial burst is not resumed.

Test Plan:
- NOP: fn=0, id=7 -> ack rises 2 cycles after req_s, ret=0, no bus_valid; req low -> ack low, busy low.
- WRB: DATA_SIZE=8, addr=0x1000, data[i]=0xA0+i, bus_ready tied 1 -> 8 consecutive beats, addrs 0x1000..0x101C, wdata 0xA0..0xA7, bus_id=id, ret=8.
- RDB with bus_ready stalls of 0..3 cycles, bus_rdata=0x55000000+i -> rdata[i] matches, ret=8, bus fields stable while stalled.
- Error on beat 3 of WRB -> exactly 4 beats issued, ret=-2; TIMEOUT=16 with bus_ready held 0 -> bus_valid drops after 16 cycles, ret=-3.
- fn=9 -> ret=-1, no beats. addr=0xFFFFFFFC with RD1 then RDB -> RDB wraps to 0x00000000 on beat 1.
- rst_n pulsed low during beat 2 with req held 1 -> ack=0 and bus_valid=0 immediately; after release the packet restarts from beat 0 and completes with a single ack.
